// File: rtl/monitor_pkg.sv
// Command-engine constants and FSM state encoding.
//   Holds the host command bytes, the response bytes and the state enum
//   shared by monitor_cmd_engine and its testbench.
package monitor_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_DUMP  = 8'h03;
    localparam logic [7:0] CMD_DEBUG = 8'h04;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ARG1,
        ARG2,
        WR_PULSE,
        RD_WAIT,
        DBG_WAIT,
        SEND
    } state_e;

endpackage

// File: rtl/monitor_cmd_engine.sv
// Byte-command engine between the UART byte streams and the core's
// programmer/debug ports.
//   clock, reset           : system clock, synchronous active-high reset
//   rx_data/valid/ready    : incoming host bytes
//   tx_data/valid/ready    : outgoing response bytes
//   prg_we/MA/WD/RD        : programmer memory port (synchronous RAM)
//   dbg_addr/data/SZCy/F0/halt : core debug register select and snapshot
//   busy                   : a command is in progress
module monitor_cmd_engine
    import monitor_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prg_we,
    output logic [7:0]  prg_MA,
    output logic [7:0]  prg_WD,
    input  logic [7:0]  prg_RD,
    output logic [2:0]  dbg_addr,
    input  logic [15:0] dbg_data,
    input  logic [2:0]  dbg_SZCy,
    input  logic        dbg_F0,
    input  logic        dbg_halt,
    output logic        busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = $clog2(RD_LAT + 2);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    ma_q, ma_d;
    logic [7:0]    wd_q, wd_d;
    logic [8:0]    cnt_q, cnt_d;    // dump bytes still to send, including current
    logic [LW-1:0] lat_q, lat_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [7:0]    txd_q, txd_d;
    logic          txv_q, txv_d;
    logic [15:0]   hold_q, hold_d;  // remaining debug snapshot bytes
    logic [1:0]    left_q, left_d;
    logic [2:0]    dbg_q, dbg_d;

    logic          rx_fire, tx_fire;
    logic [TW-1:0] tout_inc;

    assign rx_ready = !reset && (state_q inside {IDLE, ARG1, ARG2});
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = txv_q && tx_ready;
    assign tout_inc = tout_q + TW'(1);

    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign prg_we   = !reset && (state_q == WR_PULSE);
    assign prg_MA   = ma_q;
    assign prg_WD   = wd_q;
    assign dbg_addr = dbg_q;
    assign busy     = !reset && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        ma_d    = ma_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        lat_d   = '0;
        tout_d  = '0;
        txd_d   = txd_q;
        txv_d   = txv_q;
        hold_d  = hold_q;
        left_d  = left_q;
        dbg_d   = dbg_q;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                left_d = '0;
                if (rx_fire) begin
                    cmd_d = rx_data;
                    if (rx_data inside {CMD_WRITE, CMD_READ, CMD_DUMP, CMD_DEBUG}) begin
                        state_d = ARG1;
                    end else begin
                        txd_d   = RSP_NAK;
                        txv_d   = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            ARG1: begin
                if (rx_fire) begin
                    if (cmd_q == CMD_DEBUG) begin
                        dbg_d   = rx_data[2:0];
                        state_d = DBG_WAIT;
                    end else begin
                        ma_d    = rx_data;
                        state_d = (cmd_q == CMD_READ) ? RD_WAIT : ARG2;
                    end
                end else begin
                    tout_d = tout_inc;
                    if (tout_inc == TW'(TIMEOUT)) state_d = IDLE;
                end
            end
            ARG2: begin
                if (rx_fire) begin
                    if (cmd_q == CMD_WRITE) begin
                        wd_d    = rx_data;
                        state_d = WR_PULSE;
                    end else begin
                        cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        state_d = RD_WAIT;
                    end
                end else begin
                    tout_d = tout_inc;
                    if (tout_inc == TW'(TIMEOUT)) state_d = IDLE;
                end
            end
            WR_PULSE: begin
                txd_d   = RSP_ACK;
                txv_d   = 1'b1;
                state_d = SEND;
            end
            RD_WAIT: begin
                // lat_q counts cycles since prg_MA last changed
                if (lat_q == LW'(RD_LAT)) begin
                    txd_d   = prg_RD;
                    txv_d   = 1'b1;
                    state_d = SEND;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            DBG_WAIT: begin
                txd_d   = dbg_data[15:8];
                hold_d  = {dbg_data[7:0], 3'b000, dbg_halt, dbg_F0, dbg_SZCy};
                left_d  = 2'd2;
                txv_d   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (tx_fire) begin
                    if (left_q != 2'd0) begin
                        txd_d  = hold_q[15:8];
                        hold_d = {hold_q[7:0], 8'h00};
                        left_d = left_q - 2'd1;
                    end else begin
                        txv_d = 1'b0;
                        if (cnt_q > 9'd1) begin
                            cnt_d   = cnt_q - 9'd1;
                            ma_d    = ma_q + 8'd1;
                            state_d = RD_WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            ma_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tout_q  <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            hold_q  <= '0;
            left_q  <= '0;
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ma_q    <= ma_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            tout_q  <= tout_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            dbg_q   <= dbg_d;
        end
    end

endmodule

// File: tb/tb_monitor_cmd_engine.sv
// Testbench for monitor_cmd_engine: synchronous RAM and debug-register
// models around the engine, expected tx bytes queued as commands are sent
// and compared against the captured tx stream.
module tb_monitor_cmd_engine;
    import monitor_pkg::*;

    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        prg_we;
    logic [7:0]  prg_MA;
    logic [7:0]  prg_WD;
    logic [7:0]  prg_RD;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [2:0]  dbg_SZCy;
    logic        dbg_F0;
    logic        dbg_halt;
    logic        busy;

    always #5 clock = ~clock;

    monitor_cmd_engine #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .prg_we   (prg_we),
        .prg_MA   (prg_MA),
        .prg_WD   (prg_WD),
        .prg_RD   (prg_RD),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_SZCy (dbg_SZCy),
        .dbg_F0   (dbg_F0),
        .dbg_halt (dbg_halt),
        .busy     (busy)
    );

    // Synchronous RAM, one cycle read latency
    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (prg_we) mem[prg_MA] <= prg_WD;
        prg_RD <= mem[prg_MA];
    end

    logic [15:0] regs [8];
    assign dbg_data = regs[dbg_addr];

    // Monitor: capture every tx transfer and every write pulse
    int         cyc = 0;
    int         tx_count = 0;
    int         we_count = 0;
    int         txv_rise = 0;
    logic       txv_prev = 1'b0;
    logic [7:0] we_ma, we_wd;
    logic [7:0] got_mem [4096];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            got_mem[tx_count[11:0]] <= tx_data;
            tx_count <= tx_count + 1;
        end
        if (!reset && prg_we) begin
            we_count <= we_count + 1;
            we_ma    <= prg_MA;
            we_wd    <= prg_WD;
        end
        if (!reset && tx_valid && !txv_prev) txv_rise <= cyc;
        txv_prev <= tx_valid;
    end

    int         checks = 0;
    int         failures = 0;
    int         rd_idx = 0;
    logic [7:0] exp_q [$];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && k < 200) begin
            k++;
            @(negedge clock);
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_accept byte=%02h rx_ready=%b required 1 within 200 cycles", b, rx_ready);
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // Bounded wait for all queued responses to have been transmitted
    task automatic wait_tx();
        int k;
        k = 0;
        while (tx_count < rd_idx + exp_q.size() && k < 3000) begin
            @(negedge clock);
            k++;
        end
        tick(3);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        tick(3);
        @(negedge clock);
        checks++;
        if ({rx_ready, tx_valid, tx_data, prg_we, prg_MA, prg_WD, dbg_addr, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b txv=%b txd=%02h we=%b ma=%02h wd=%02h da=%0d busy=%b required all 0",
                     rx_ready, tx_valid, tx_data, prg_we, prg_MA, prg_WD, dbg_addr, busy);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rx_ready=%b busy=%b required 1 0", rx_ready, busy);
        end
        tick(1);
    endtask

    task automatic test_write(input logic [7:0] a, input logic [7:0] d);
        int wb;
        logic [7:0] e;
        wb = we_count;
        exp_q.push_back(RSP_ACK);
        send_byte(CMD_WRITE);
        send_byte(a);
        send_byte(d);
        wait_tx();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= tx_count || got_mem[rd_idx[11:0]] !== e) begin
                failures++;
                $display("FAIL write_rsp got %02h (count %0d) required %02h", got_mem[rd_idx[11:0]], tx_count, e);
            end
            rd_idx++;
        end
        checks++;
        if (we_count - wb != 1 || we_ma !== a || we_wd !== d) begin
            failures++;
            $display("FAIL write_pulse got cycles=%0d ma=%02h wd=%02h required 1 %02h %02h",
                     we_count - wb, we_ma, we_wd, a, d);
        end
        checks++;
        if (mem[a] !== d) begin
            failures++;
            $display("FAIL write_mem got %02h required %02h", mem[a], d);
        end
    endtask

    task automatic test_read();
        int wb, acc;
        logic [7:0] e;
        wb = we_count;
        exp_q.push_back(8'hA5);
        send_byte(CMD_READ);
        send_byte(8'h10);
        acc = cyc;
        wait_tx();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= tx_count || got_mem[rd_idx[11:0]] !== e) begin
                failures++;
                $display("FAIL read_data got %02h (count %0d) required %02h", got_mem[rd_idx[11:0]], tx_count, e);
            end
            rd_idx++;
        end
        checks++;
        if (txv_rise - acc < int'(RD_LAT) + 1) begin
            failures++;
            $display("FAIL read_latency got %0d cycles required >= %0d", txv_rise - acc, RD_LAT + 1);
        end
        checks++;
        if (we_count != wb) begin
            failures++;
            $display("FAIL read_no_write got %0d write cycles required 0", we_count - wb);
        end
    endtask

    task automatic test_dump_stall();
        int k;
        logic [7:0] d0, e;
        test_write(8'hFE, 8'h11);
        test_write(8'hFF, 8'h22);
        test_write(8'h00, 8'h33);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_byte(CMD_DUMP);
        send_byte(8'hFE);
        send_byte(8'h03);
        k = 0;
        while (tx_count < rd_idx + 1 && k < 200) begin
            @(negedge clock);
            k++;
        end
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 200) begin
            @(negedge clock);
            k++;
        end
        d0 = tx_data;
        repeat (5) begin
            @(negedge clock);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== d0) begin
                failures++;
                $display("FAIL dump_stall got txv=%b txd=%02h required 1 %02h", tx_valid, tx_data, d0);
            end
        end
        tx_ready = 1'b1;
        wait_tx();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= tx_count || got_mem[rd_idx[11:0]] !== e) begin
                failures++;
                $display("FAIL dump_data got %02h (count %0d) required %02h", got_mem[rd_idx[11:0]], tx_count, e);
            end
            rd_idx++;
        end
        checks++;
        if (tx_count != rd_idx) begin
            failures++;
            $display("FAIL dump_count got %0d bytes required %0d", tx_count, rd_idx);
        end
    endtask

    task automatic test_debug(input logic [2:0] sel, input logic [15:0] word,
                              input logic [2:0] szcy, input logic f0, input logic halt);
        logic [7:0] e;
        regs[sel] = word;
        dbg_SZCy  = szcy;
        dbg_F0    = f0;
        dbg_halt  = halt;
        exp_q.push_back(word[15:8]);
        exp_q.push_back(word[7:0]);
        exp_q.push_back({3'b000, halt, f0, szcy});
        send_byte(CMD_DEBUG);
        send_byte({5'b10100, sel});
        wait_tx();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= tx_count || got_mem[rd_idx[11:0]] !== e) begin
                failures++;
                $display("FAIL debug_bytes got %02h (count %0d) required %02h", got_mem[rd_idx[11:0]], tx_count, e);
            end
            rd_idx++;
        end
        checks++;
        if (dbg_addr !== sel || tx_count != rd_idx) begin
            failures++;
            $display("FAIL debug_sel got addr=%0d bytes=%0d required %0d %0d", dbg_addr, tx_count, sel, rd_idx);
        end
    endtask

    task automatic test_timeout();
        int wb, tc;
        logic [7:0] e;
        wb = we_count;
        tc = tx_count;
        send_byte(CMD_WRITE);
        send_byte(8'h10);
        tick(TIMEOUT + 4);
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_idle got busy=%b rx_ready=%b required 0 1", busy, rx_ready);
        end
        checks++;
        if (tx_count != tc || we_count != wb) begin
            failures++;
            $display("FAIL timeout_silent got tx=%0d we=%0d required 0 0", tx_count - tc, we_count - wb);
        end
        exp_q.push_back(RSP_NAK);
        send_byte(8'h7E);
        wait_tx();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_idx >= tx_count || got_mem[rd_idx[11:0]] !== e) begin
                failures++;
                $display("FAIL nak_rsp got %02h (count %0d) required %02h", got_mem[rd_idx[11:0]], tx_count, e);
            end
            rd_idx++;
        end
    endtask

    task automatic test_reset_mid_dump();
        int k;
        send_byte(CMD_DUMP);
        send_byte(8'h00);
        send_byte(8'h08);
        k = 0;
        while (tx_count < rd_idx + 2 && k < 200) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL dump_busy got %b required 1", busy);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || prg_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_cmd got txv=%b busy=%b we=%b required 0 0 0", tx_valid, busy, prg_we);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(2);
        rd_idx = tx_count;
        test_read();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        dbg_SZCy = 3'b000;
        dbg_F0   = 1'b0;
        dbg_halt = 1'b0;
        test_reset();
        test_write(8'h10, 8'hA5);
        test_read();
        test_dump_stall();
        test_debug(3'd5, 16'hBEEF, 3'b010, 1'b1, 1'b0);
        test_debug(3'd0, 16'h207F, 3'b101, 1'b0, 1'b1);
        test_timeout();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/monitor_cmd_engine.md
Name: monitor_cmd_engine

Overview:
- Byte-command engine between the serial link (UART rx/tx byte streams) and the CPU core's programmer and debug ports.
- Decodes host commands into programmer-port memory writes, reads and dumps, and debug-register snapshots.
- Returns response bytes on the tx stream.
- Runs on the system clock; the top level ties the core's prg_clock to the same clock.

Parameters:
- RD_LAT, 1: cycles from prg_MA change to valid prg_RD (synchronous RAM).
- TIMEOUT, 1000000: idle cycles allowed between argument bytes before the command is aborted.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  engine accepts rx byte
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- prg_we  out  1  programmer write enable
- prg_MA  out  8  programmer memory address
- prg_WD  out  8  programmer write data
- prg_RD  in  8  programmer read data
- dbg_addr  out  3  core debug register select
- dbg_data  in  16  core debug word
- dbg_SZCy  in  3  core flags
- dbg_F0  in  1  core fetch-phase flag
- dbg_halt  in  1  core halted
- busy  out  1  command in progress (state != IDLE)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0 (rx_ready, tx_valid, tx_data, prg_we, prg_MA, prg_WD, dbg_addr, busy); state IDLE. In the cycle after reset deasserts, rx_ready=1.
- Reset mid-command: abandons the command; any pending tx byte is dropped; prg_we is forced 0.
- rx transfer: rx_valid && rx_ready. rx_ready=1 only in IDLE, ARG1 and ARG2.
- tx transfer: tx_valid && tx_ready. While tx_valid=1 && tx_ready=0, tx_data holds stable. tx_valid drops in the cycle after the last byte transfers. No timeout while waiting on tx_ready.
- Commands (first byte, then arguments):
  - 0x01 WRITE addr data: prg_MA=addr and prg_WD=data are set, then prg_we=1 for exactly one cycle. Then respond 0x06 (ACK).
  - 0x02 READ addr: prg_MA=addr; wait RD_LAT cycles; capture prg_RD; respond with the captured byte.
  - 0x03 DUMP addr cnt: stream cnt bytes (cnt=0 means 256) from addr upward. Address wraps 0xFF->0x00. Each byte is read with RD_LAT wait, then sent. The next address is issued only after the previous byte has transferred.
  - 0x04 DEBUG sel: dbg_addr=sel[2:0], held after the command. Wait 1 cycle. Capture dbg_data and flags into a holding register, then send 3 bytes:
    - dbg_data[15:8]
    - dbg_data[7:0]
    - {3'b000, dbg_halt, dbg_F0, dbg_SZCy}
  - Any other command byte: respond 0x15 (NAK), return to IDLE.
- FSM states and transitions:
  - IDLE -> ARG1 on 0x01..0x04; IDLE -> SEND on an unknown command.
  - ARG1 -> ARG2 for 0x01 and 0x03.
  - ARG1 -> RD_WAIT for 0x02; ARG1 -> DBG_WAIT for 0x04.
  - ARG2 -> WR_PULSE for 0x01; ARG2 -> RD_WAIT for 0x03.
  - WR_PULSE -> SEND.
  - RD_WAIT -> SEND once RD_LAT cycles have elapsed.
  - DBG_WAIT -> SEND (3 bytes).
  - SEND -> RD_WAIT if dump count remains, else IDLE.
- Timeout: a counter clears on every accepted rx byte. If it reaches TIMEOUT while in ARG1 or ARG2, go to IDLE with no response and no memory write.
- Outside WR_PULSE, prg_we=0. prg_MA and prg_WD retain their last values when idle.
- A byte presented in the same cycle a command completes is not accepted until IDLE (rx_ready=0 in SEND).

Decomposition:
- monitor_pkg holds:
  - command constants: CMD_WRITE=0x01, CMD_READ=0x02, CMD_DUMP=0x03, CMD_DEBUG=0x04, RSP_ACK=0x06, RSP_NAK=0x15
  - state enum: IDLE, ARG1, ARG2, WR_PULSE, RD_WAIT, DBG_WAIT, SEND
- No sub-module is required; single FSM plus datapath registers. The timeout counter stays inline.

Test Plan:
- rx 0x01,0x10,0xA5 -> prg_MA=0x10 and prg_WD=0xA5 with prg_we high exactly 1 cycle; tx 0x06; memory[0x10]=0xA5.
- After the write above, rx 0x02,0x10 -> tx 0xA5, emitted RD_LAT+1 or more cycles after the addr byte; prg_we stays 0.
- Preload mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33; rx 0x03,0xFE,0x03 -> tx 0x11,0x22,0x33. Hold tx_ready=0 for 5 cycles mid-stream -> tx_data stable, no bytes lost.
- Core with A=0x7F, PC=0x20, SZCy=3'b101, halt=1; rx 0x04,0x00 -> dbg_addr=0; tx 0x20,0x7F,0x15.
- rx 0x01,0x10 then silence TIMEOUT cycles (bench TIMEOUT=16) -> returns to IDLE, no tx, prg_we never asserted. Next rx 0x7E -> tx 0x15.
- Assert reset during DUMP of 8 bytes -> next cycle tx_valid=0, busy=0, prg_we=0. Fresh READ works afterwards.
